// File: rtl/tsu_ts_readout_arbiter_if.sv
// Bundle of handshake and bus signals for tsu_ts_readout_arbiter.
// Signal suffixes are from the arbiter's point of view (_i into it, _o out of it).
//   enable_i               arbitration enable
//   rx_ts_* / tx_ts_*      capture-queue head records (valid/data in, ready/pop out)
//   bus2ip_* / ip2bus_*    32-bit register bus (one-cycle read/write strobes)
//   int_ts_o               level interrupt while a record is held
//   drop_cnt_o             count of records discarded by timeout
// modport slave is the arbiter; modport master is whatever drives it.
interface tsu_ts_readout_arbiter_if;
  logic        enable_i;
  logic        rx_ts_valid_i;
  logic [95:0] rx_ts_data_i;
  logic        rx_ts_ready_o;
  logic        tx_ts_valid_i;
  logic [95:0] tx_ts_data_i;
  logic        tx_ts_ready_o;
  logic [31:0] bus2ip_addr_i;
  logic [31:0] bus2ip_data_i;
  logic        bus2ip_rd_ce_i;
  logic        bus2ip_wr_ce_i;
  logic [31:0] ip2bus_data_o;
  logic        int_ts_o;
  logic [15:0] drop_cnt_o;

  modport master (
    output enable_i, rx_ts_valid_i, rx_ts_data_i, tx_ts_valid_i, tx_ts_data_i,
           bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
    input  rx_ts_ready_o, tx_ts_ready_o, ip2bus_data_o, int_ts_o, drop_cnt_o
  );

  modport slave (
    input  enable_i, rx_ts_valid_i, rx_ts_data_i, tx_ts_valid_i, tx_ts_data_i,
           bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
    output rx_ts_ready_o, tx_ts_ready_o, ip2bus_data_o, int_ts_o, drop_cnt_o
  );
endinterface

// File: rtl/tsu_ts_readout_arbiter.sv
// Shares the CPU timestamp readout path between the RX and TX capture queues.
// A round-robin grant pops one record into holding registers and raises
// int_ts_o until software writes ACK or the record times out; a one-cycle
// GAP then guarantees a visible interrupt edge between records.
// Ports:
//   bus2ip_clk    clock for all logic
//   bus2ip_rst_n  asynchronous active-low reset
//   bus           tsu_ts_readout_arbiter_if.slave (queues, register bus, irq, drop count)
// Register window (word offsets from BASE_ADDR):
//   0x00 STATUS  0x04 SEC_HI  0x08 SEC_LO  0x0C NS  0x10 SEQ  0x14 ACK  0x18 DROP_CLR
module tsu_ts_readout_arbiter #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                      bus2ip_clk,
  input logic                      bus2ip_rst_n,
  tsu_ts_readout_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [47:0] sec_q;
  logic [31:0] ns_q;
  logic [15:0] seq_q;
  logic        src_q;         // 0 = RX, 1 = TX
  logic        last_grant_q;  // resets to TX so RX wins the first tie
  logic        int_q;
  logic [15:0] tmo_cnt_q;
  logic [15:0] drop_q, drop_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux;

  // Window decode: 64-byte aligned, byte offset bits [1:0] ignored.
  logic       in_win;
  logic [3:0] word;
  logic       ack_hit, clr_hit, timeout_hit;
  logic       grant_ok, grant_rx, grant_tx;
  logic       unused_bits;

  assign in_win  = (bus.bus2ip_addr_i[31:6] == BASE_ADDR[31:6]);
  assign word    = bus.bus2ip_addr_i[5:2];
  assign ack_hit = bus.bus2ip_wr_ce_i & in_win & (word == 4'h5) & bus.bus2ip_data_i[0];
  assign clr_hit = bus.bus2ip_wr_ce_i & in_win & (word == 4'h6);

  // Ack takes priority over a timeout landing in the same cycle.
  assign timeout_hit = (state_q == HOLD) & ~ack_hit & (tmo_cnt_q == TMO_LAST);

  // No pop while reset is held: the holding registers could not capture it.
  assign grant_ok = bus2ip_rst_n & (state_q == IDLE) & bus.enable_i;
  assign grant_rx = grant_ok & bus.rx_ts_valid_i & (~bus.tx_ts_valid_i | last_grant_q);
  assign grant_tx = grant_ok & bus.tx_ts_valid_i & (~bus.rx_ts_valid_i | ~last_grant_q);

  assign bus.rx_ts_ready_o = grant_rx;
  assign bus.tx_ts_ready_o = grant_tx;
  assign bus.int_ts_o      = int_q;
  assign bus.drop_cnt_o    = drop_q;
  assign bus.ip2bus_data_o = rdata_q;

  assign unused_bits = ^{bus.bus2ip_data_i[31:1], bus.bus2ip_addr_i[1:0]};

  // A DROP_CLR coinciding with a drop leaves exactly that one drop counted.
  always_comb begin
    drop_d = drop_q;
    if (clr_hit) begin
      drop_d = timeout_hit ? 16'd1 : 16'd0;
    end else if (timeout_hit && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      4'h0: rd_mux = {drop_q, 12'h000, bus.tx_ts_valid_i, bus.rx_ts_valid_i,
                      src_q, (state_q == HOLD)};
      4'h1: rd_mux = {16'h0000, sec_q[47:32]};
      4'h2: rd_mux = sec_q[31:0];
      4'h3: rd_mux = ns_q;
      4'h4: rd_mux = {16'h0000, seq_q};
      default: rd_mux = '0;
    endcase
    rdata_d = (bus.bus2ip_rd_ce_i & in_win) ? rd_mux : 32'h0;
  end

  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state_q      <= IDLE;
      sec_q        <= '0;
      ns_q         <= '0;
      seq_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      int_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      drop_q       <= '0;
      rdata_q      <= '0;
    end else begin
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
      case (state_q)
        IDLE: begin
          if (grant_rx || grant_tx) begin
            state_q      <= HOLD;
            int_q        <= 1'b1;
            src_q        <= grant_tx;
            last_grant_q <= grant_tx;
            tmo_cnt_q    <= '0;
            {sec_q, ns_q, seq_q} <= grant_tx ? bus.tx_ts_data_i : bus.rx_ts_data_i;
          end
        end
        HOLD: begin
          if (ack_hit || timeout_hit) begin
            state_q <= GAP;
            int_q   <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsu_ts_readout_arbiter.sv
`timescale 1ns/1ps
module tb_tsu_ts_readout_arbiter;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          T    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tsu_ts_readout_arbiter_if bus_if();

  tsu_ts_readout_arbiter #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
    .bus2ip_clk  (clk),
    .bus2ip_rst_n(rst_n),
    .bus         (bus_if)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          int_lvl;
    logic [15:0] drop;
    logic [31:0] rdata;
  } cyc_exp_t;

  cyc_exp_t cyc_q[$];
  bit       grant_q[$];   // expected granted source per pop: 0=RX, 1=TX
  int       n_pass = 0;
  int       n_total = 0;

  task automatic check(bit ok, string name, logic [95:0] act, logic [95:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks the record being held (and for how long), the one-cycle pause after
  // a release, the round-robin history and the drop tally.
  bit          m_held, m_gap, m_src, m_last;
  int          m_age;
  logic [95:0] m_rec;
  logic [15:0] m_drop;
  logic [31:0] pend_rdata;

  task automatic model_reset();
    m_held = 0; m_gap = 0; m_src = 0; m_last = 1; m_age = 0;
    m_rec = '0; m_drop = '0; pend_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(logic [31:0] addr, bit rv, bit tv);
    logic [31:0] off;
    if (addr < BASE || (addr - BASE) >= 32'd64) return 32'h0;
    off = (addr - BASE) & 32'hFFFF_FFFC;
    case (off)
      32'h00: return {m_drop, 12'h000, tv, rv, m_src, m_held};
      32'h04: return {16'h0000, m_rec[95:80]};
      32'h08: return m_rec[79:48];
      32'h0C: return m_rec[47:16];
      32'h10: return {16'h0000, m_rec[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Drives one clock cycle of stimulus, records what the DUT must show during
  // it, then advances the model across the closing clock edge.
  task automatic cycle(bit en, bit rv, logic [95:0] rd, bit tv, logic [95:0] td,
                       bit rdo, bit wro, logic [31:0] addr, logic [31:0] wd);
    cyc_exp_t    e;
    bit          in_w, ack, clr, drop_ev;
    logic [31:0] off;
    @(posedge clk); #1;
    bus_if.enable_i       = en;
    bus_if.rx_ts_valid_i  = rv;
    bus_if.rx_ts_data_i   = rd;
    bus_if.tx_ts_valid_i  = tv;
    bus_if.tx_ts_data_i   = td;
    bus_if.bus2ip_rd_ce_i = rdo;
    bus_if.bus2ip_wr_ce_i = wro;
    bus_if.bus2ip_addr_i  = addr;
    bus_if.bus2ip_data_i  = wd;

    e.int_lvl = m_held;
    e.drop    = m_drop;
    e.rdata   = pend_rdata;
    cyc_q.push_back(e);
    pend_rdata = rdo ? model_read(addr, rv, tv) : 32'h0;

    off  = addr - BASE;
    in_w = (addr >= BASE) && (off < 32'd64);
    ack  = wro && in_w && (off / 4 == 5) && wd[0];
    clr  = wro && in_w && (off / 4 == 6);
    drop_ev = 0;
    if (m_held) begin
      if (ack) begin
        m_held = 0; m_gap = 1;
      end else if (m_age == T - 1) begin
        m_held = 0; m_gap = 1; drop_ev = 1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (en && (rv || tv)) begin
      m_src  = (rv && tv) ? !m_last : tv;
      m_rec  = m_src ? td : rd;
      m_last = m_src;
      m_held = 1;
      m_age  = 0;
      grant_q.push_back(m_src);
    end
    if (clr) m_drop = drop_ev ? 16'd1 : 16'd0;
    else if (drop_ev && m_drop != 16'hFFFF) m_drop++;
  endtask

  task automatic bus_rd(logic [31:0] a);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic bus_wr(logic [31:0] a, logic [31:0] d);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Bring the model (and DUT) back to idle by acking whatever is held.
  task automatic settle();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, m_held, BASE + 32'h14, 32'h1);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic async_reset_mid_cycle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    bus_if.enable_i = 1'b1;
    bus_if.rx_ts_valid_i = 1'b1;
    bus_if.tx_ts_valid_i = 1'b1;
    bus_if.bus2ip_rd_ce_i = 1'b0;
    bus_if.bus2ip_wr_ce_i = 1'b0;
    #1;
    check(bus_if.int_ts_o === 1'b0, "rst_int_immediate", bus_if.int_ts_o, 0);
    check({bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o} === 2'b00, "rst_no_ready",
          {bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check(bus_if.drop_cnt_o === 16'h0, "rst_drop", bus_if.drop_cnt_o, 0);
    check(bus_if.ip2bus_data_o === 32'h0, "rst_rdata", bus_if.ip2bus_data_o, 0);
    bus_if.rx_ts_valid_i = 1'b0;
    bus_if.tx_ts_valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  cyc_exp_t mon_e;
  bit       mon_s;
  initial begin
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        mon_e = cyc_q.pop_front();
        check(bus_if.int_ts_o === mon_e.int_lvl, "int_ts", bus_if.int_ts_o, mon_e.int_lvl);
        check(bus_if.drop_cnt_o === mon_e.drop, "drop_cnt", bus_if.drop_cnt_o, mon_e.drop);
        check(bus_if.ip2bus_data_o === mon_e.rdata, "rdata", bus_if.ip2bus_data_o, mon_e.rdata);
        if (bus_if.rx_ts_ready_o || bus_if.tx_ts_ready_o) begin
          if (grant_q.size() == 0) begin
            check(1'b0, "grant_unexpected",
                  {bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o}, 0);
          end else begin
            mon_s = grant_q.pop_front();
            check({bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o} === (mon_s ? 2'b01 : 2'b10),
                  "grant_src", {bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o},
                  mon_s ? 2'b01 : 2'b10);
          end
        end else if (grant_q.size() > 0) begin
          mon_s = grant_q.pop_front();
          check(1'b0, "grant_missing", 0, mon_s ? 2'b01 : 2'b10);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_if.enable_i = 1'b1;
    bus_if.rx_ts_valid_i = 1'b1;
    bus_if.rx_ts_data_i = '0;
    bus_if.tx_ts_valid_i = 1'b1;
    bus_if.tx_ts_data_i = '0;
    bus_if.bus2ip_addr_i = '0;
    bus_if.bus2ip_data_i = '0;
    bus_if.bus2ip_rd_ce_i = 1'b0;
    bus_if.bus2ip_wr_ce_i = 1'b0;
    model_reset();

    // Reset values, with valid+enable applied: nothing may be popped.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o} === 2'b00, "reset_ready",
          {bus_if.rx_ts_ready_o, bus_if.tx_ts_ready_o}, 0);
    check(bus_if.int_ts_o === 1'b0, "reset_int", bus_if.int_ts_o, 0);
    check(bus_if.drop_cnt_o === 16'h0, "reset_drop", bus_if.drop_cnt_o, 0);
    check(bus_if.ip2bus_data_o === 32'h0, "reset_rdata", bus_if.ip2bus_data_o, 0);
    #2;
    rst_n = 1'b1;
    bus_if.rx_ts_valid_i = 1'b0;
    bus_if.tx_ts_valid_i = 1'b0;

    // Single RX record, then read back every holding register and STATUS.
    cycle(1'b1, 1'b1, {48'h1, 32'h3B9A_C9FF, 16'h0042}, 1'b0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus_rd(BASE + 32'h04);
    bus_rd(BASE + 32'h08);
    bus_rd(BASE + 32'h0C);
    bus_rd(BASE + 32'h10);
    bus_rd(BASE + 32'h00);
    bus_rd(BASE + 32'h14);
    bus_wr(BASE + 32'h14, 32'h1);
    bus_rd(BASE + 32'h08);   // last record still readable after release
    idle_cycles(2);

    // Both queues valid continuously, ack as soon as each record is held.
    settle();
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b1, rnd96(), 1'b1, rnd96(), 1'b0, m_held, BASE + 32'h14, 32'h1);
    settle();

    // Timeout without ack -> one drop, visible in STATUS, then DROP_CLR.
    cycle(1'b1, 1'b0, '0, 1'b1, rnd96(), 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycles(T + 2);
    bus_rd(BASE + 32'h00);
    bus_wr(BASE + 32'h18, 32'hDEAD_BEEF);
    bus_rd(BASE + 32'h00);
    idle_cycles(1);

    // Ack landing on the last counted cycle must win over the timeout.
    settle();
    cycle(1'b1, 1'b1, rnd96(), 1'b0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < T + 2; i++)
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, m_held && (m_age == T - 1), BASE + 32'h14, 32'h1);

    // Disabled: no pops. Disable during HOLD: ack still releases, no new grant.
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, rnd96(), 1'b1, rnd96(), 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, rnd96(), 1'b1, rnd96(), 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, rnd96(), 1'b1, rnd96(), 1'b0, (i == 3), BASE + 32'h14, 32'h1);

    // Asynchronous reset while a record is held.
    settle();
    cycle(1'b1, 1'b0, '0, 1'b1, rnd96(), 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycles(2);
    async_reset_mid_cycle();
    cycle(1'b1, 1'b1, rnd96(), 1'b1, rnd96(), 1'b0, 1'b0, 32'h0, 32'h0);
    bus_rd(BASE + 32'h00);
    settle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          en, rv, tv, rdo, wro;
      logic [31:0] a, d;
      int          op;
      en  = ($urandom_range(0, 9) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      tv  = ($urandom_range(0, 2) != 0);
      rdo = 0; wro = 0; a = 32'h0; d = $urandom;
      op  = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin
          rdo = 1; a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        end
        3: begin
          rdo = 1;
          a = ($urandom_range(0, 1) != 0) ? BASE + 32'h40 + 32'(4 * $urandom_range(0, 15))
                                          : BASE - 32'(4 * $urandom_range(1, 8));
        end
        4: begin wro = 1; a = BASE + 32'h14; d = d | 32'h1; end
        5: begin wro = 1; a = BASE + 32'h14; d = d & 32'hFFFF_FFFE; end
        6: if ($urandom_range(0, 3) == 0) begin wro = 1; a = BASE + 32'h18; end
        7: begin wro = 1; a = BASE + 32'h1C + 32'(4 * $urandom_range(0, 8)); end
        default: ;
      endcase
      cycle(en, rv, rnd96(), tv, rnd96(), rdo, wro, a, d);
    end
    idle_cycles(2);

    @(negedge clk); #1;
    check(cyc_q.size() == 0, "cycle_queue_drained", cyc_q.size(), 0);
    check(grant_q.size() == 0, "grant_queue_drained", grant_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tsu_ts_readout_arbiter.md
Name: tsu_ts_readout_arbiter

Overview:
Bus-clock-domain controller that shares the single CPU timestamp readout path between the RX and TX timestamp capture queues of the PTPv2 timestamp unit. Round-robin arbitration picks one pending timestamp record, latches it into holding registers and raises an interrupt. It holds the record until software acknowledges it over the 32-bit on-chip bus or a timeout discards it. It sits between the clock-crossed RX/TX capture FIFOs and the timestamp unit's bus register file.

Parameters:
BASE_ADDR, 32'h0000_0100, byte base address of this block's register window (64-byte aligned)
TIMEOUT_CYCLES, 65535, bus2ip_clk cycles a record is held unacknowledged before it is discarded; legal range 2..65535

Ports:
bus2ip_clk  input  1  bus clock; all logic is on this clock
bus2ip_rst_n  input  1  asynchronous active-low reset
enable_i  input  1  arbitration enable; tie to ~dis_ptpv2
rx_ts_valid_i  input  1  RX queue head record valid
rx_ts_data_i  input  96  RX record: [95:48] seconds, [47:16] nanoseconds, [15:0] sequenceId
rx_ts_ready_o  output  1  RX pop strobe
tx_ts_valid_i  input  1  TX queue head record valid
tx_ts_data_i  input  96  TX record, same layout
tx_ts_ready_o  output  1  TX pop strobe
bus2ip_addr_i  input  32  byte address
bus2ip_data_i  input  32  write data
bus2ip_rd_ce_i  input  1  read strobe, active high, one cycle
bus2ip_wr_ce_i  input  1  write strobe, active high, one cycle
ip2bus_data_o  output  32  read data
int_ts_o  output  1  level interrupt: record held
drop_cnt_o  output  16  timeout discard count

Behaviour:
- Clock and reset: single clock bus2ip_clk; reset bus2ip_rst_n is asynchronous and active-low.
- Reset values:
  - ready outputs, int_ts_o, ip2bus_data_o, drop_cnt_o, holding regs, timeout counter: 0.
  - FSM state: IDLE.
  - last_grant: TX, so RX wins the first tie.
- FSM states: IDLE, HOLD, GAP.
- IDLE, when enable_i=1 and a valid is present:
  - Only one valid: grant it.
  - Both valid: grant the side opposite last_grant.
  - The granted ready is asserted combinationally in that same cycle (one-cycle pop).
  - On that edge: latch data, record source (0=RX, 1=TX), update last_grant, clear timeout counter, go to HOLD.
  - enable_i=0 or no valid: stay in IDLE, ready=0.
- HOLD:
  - int_ts_o=1 (registered, so it goes high the cycle after the grant).
  - Timeout counter increments each cycle.
  - Write of 1 to ACK[0] -> GAP.
  - Counter reaching TIMEOUT_CYCLES-1 with no ack -> GAP, and drop_cnt increments, saturating at 16'hFFFF.
  - Ack and timeout in the same cycle: ack wins, no drop.
  - Deasserting enable_i in HOLD does not abort; the record completes normally.
- GAP: one cycle, int_ts_o=0, no grant, then IDLE. This guarantees the interrupt edge is visible between records.
- ACK write outside HOLD: ignored.
- Register map (offset from BASE_ADDR, 32-bit aligned; address bits [1:0] ignored):
  - 0x00 STATUS: [0] held (state==HOLD), [1] source, [2] rx_valid, [3] tx_valid, [31:16] drop_cnt.
  - 0x04 SEC_HI: {16'h0, sec[47:32]}.
  - 0x08 SEC_LO: sec[31:0].
  - 0x0C NS: ns[31:0].
  - 0x10 SEQ: {16'h0, seqId}.
  - 0x14 ACK: write-only, [0]=ack; reads 0.
  - 0x18 DROP_CLR: write any value clears drop_cnt; if a drop occurs in the same cycle, the result is 1.
  - Unmapped offsets within the window read 0; writes to them have no effect.
- Reads:
  - ip2bus_data_o is registered, valid exactly 1 cycle after bus2ip_rd_ce_i, and 0 in all other cycles.
  - Holding regs are only updated on a grant, so reads in HOLD are stable.
  - Reads of holding regs in IDLE/GAP return the last record.
- Addresses outside BASE_ADDR..BASE_ADDR+0x3F: no decode; read data stays 0.
- Reset asserted mid-HOLD: immediate return to IDLE and int_ts_o=0. The held record is lost and is not counted as a drop.

Test Plan:
- Reset, then RX valid with data {48'h1, 32'h3B9A_C9FF, 16'h0042} -> rx_ts_ready_o pulses 1 cycle; int_ts_o high next cycle. Reads return SEC_HI=0, SEC_LO=1, NS=3B9AC9FF, SEQ=0042, STATUS[1:0]=2'b01.
- RX and TX valid together continuously, with ack after each interrupt -> grant order RX, TX, RX, TX. Each ack is followed by 1 GAP cycle with int_ts_o=0 before the next grant.
- TIMEOUT_CYCLES=8, no ack -> int_ts_o falls 8 cycles after rising; drop_cnt_o=1; STATUS[31:16]=1. Write DROP_CLR -> 0.
- TIMEOUT_CYCLES=8, ack written in the cycle the counter reaches 7 -> no drop; drop_cnt_o stays 0.
- enable_i=0 with both valid -> no ready ever. Deassert enable_i during HOLD -> ack still releases the record; no further grants.
- Assert bus2ip_rst_n=0 asynchronously mid-HOLD -> int_ts_o=0 immediately. After release: IDLE, drop_cnt_o=0, RX granted first on a tie.
